// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift engine: default sizes,
// operation codes, FSM state encoding and the fill-bit helper.
package shift_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_STEP  = 4;

    // Operation codes as presented on in_mode
    typedef enum logic [1:0] {
        MODE_SLL = 2'd0,
        MODE_SRA = 2'd1,
        MODE_SRL = 2'd2,
        MODE_ROR = 2'd3
    } mode_e;

    // Engine FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit shifted in from the top: the sign bit for SRA, zero otherwise
    function automatic logic fill_bit(input mode_e mode, input logic msb);
        return (mode == MODE_SRA) ? msb : 1'b0;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One partial shift step: shifts a WIDTH-bit value by k (0..STEP) bits.
// Ports:
//   data   - value to shift
//   k      - bits to shift this step, 0..STEP
//   mode   - SLL / SRA / SRL / ROR
//   fill   - bit entering from the top for right shifts (sign for SRA)
//   result - shifted value
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned STEP  = DEF_STEP,
    parameter int unsigned K_W   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [K_W-1:0]   k,
    input  mode_e            mode,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] ext;

    // Right shifts and the rotate share one double-width shifter: the upper
    // half supplies the fill bits (replicated fill, or a copy of data for ROR).
    always_comb begin
        ext = {{WIDTH{fill}}, data};
        if (mode == MODE_ROR) begin
            ext = {data, data};
        end
        if (mode == MODE_SLL) begin
            result = data << k;
        end else begin
            result = WIDTH'(ext >> k);
        end
    end

endmodule

// File: rtl/shift_engine.sv
// Multi-cycle shifter: accepts one request, shifts it by at most STEP bits
// per clock, then holds the result until the consumer takes it.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   in_valid/in_ready  - request handshake (in_ready only in IDLE)
//   in_data, in_shamt  - operand and shift amount
//   in_mode            - 0 SLL, 1 SRA, 2 SRL, 3 ROR
//   out_valid/out_ready- result handshake (out_valid only in DONE)
//   out_data, out_zero - result (0 when not valid) and its zero flag
//   busy               - engine is not IDLE
module shift_engine
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned STEP    = DEF_STEP,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero,
    output logic               busy
);

    localparam int unsigned K_W = $clog2(STEP + 1);

    state_e             state;
    mode_e              mode;
    logic               fill;
    logic [SHAMT_W-1:0] remaining;
    logic [WIDTH-1:0]   work;
    logic [K_W-1:0]     k;
    logic [WIDTH-1:0]   step_result;
    mode_e              in_mode_e;

    assign in_mode_e = mode_e'(in_mode);

    // Bits to shift this cycle: min(STEP, remaining)
    always_comb begin
        if (32'(remaining) >= STEP) begin
            k = K_W'(STEP);
        end else begin
            k = K_W'(remaining);
        end
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .K_W   (K_W)
    ) u_step (
        .data   (work),
        .k      (k),
        .mode   (mode),
        .fill   (fill),
        .result (step_result)
    );

    // Control FSM with all outputs registered.
    // A zero-amount request enters DONE directly but raises out_valid one
    // edge later, so every request has a latency of at least one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode      <= MODE_SLL;
            fill      <= 1'b0;
            remaining <= '0;
            work      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        work      <= in_data;
                        mode      <= in_mode_e;
                        fill      <= fill_bit(in_mode_e, in_data[WIDTH-1]);
                        remaining <= in_shamt;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= (in_shamt == '0) ? ST_DONE : ST_RUN;
                    end
                end

                ST_RUN: begin
                    work      <= step_result;
                    remaining <= remaining - SHAMT_W'(k);
                    // Last step: publish the result on the same edge
                    if (remaining == SHAMT_W'(k)) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        out_data  <= step_result;
                        out_zero  <= (step_result == '0);
                    end
                end

                ST_DONE: begin
                    if (!out_valid) begin
                        // Zero-amount request: operand passes through unchanged
                        out_valid <= 1'b1;
                        out_data  <= work;
                        out_zero  <= (work == '0);
                    end else if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_zero  <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_engine.sv
// Scoreboard bench for shift_engine (WIDTH=32, STEP=4): the driver pushes the
// hand-computed result and the edge on which out_valid must rise; a monitor
// pops and compares whenever out_valid rises.
module tb_shift_engine;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = 5;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_zero;
    logic               busy;

    typedef struct {
        logic [31:0] data;
        logic        zero;
        int          edge_no;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    logic prev_valid = 1'b0;

    shift_engine #(.WIDTH(32), .STEP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: idle outputs must be zero; each rising out_valid is scored
    always @(negedge clk) begin
        if (!rst) begin
            if (!out_valid) begin
                chk("idle_out_data", out_data, 32'h0);
            end else if (!prev_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result_data", out_data, e.data);
                    chk("result_zero", 32'(out_zero), 32'(e.zero));
                    chk("result_latency_edge", 32'(edge_cnt), 32'(e.edge_no));
                end
            end
        end
        prev_valid = out_valid;
    end

    // Issue one request; called at a negedge, returns at the negedge after accept
    task automatic send(input logic [1:0] mode, input logic [31:0] data,
                        input logic [4:0] shamt, input logic [31:0] exp,
                        input int lat, input bit track);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'h1);
            return;
        end
        in_valid = 1'b1;
        in_data  = data;
        in_shamt = shamt;
        in_mode  = mode;
        if (track) sb.push_back('{exp, (exp == 32'h0), edge_cnt + 1 + lat});
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        in_shamt = 5'd17;
        in_mode  = 2'd3;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(in_ready && !busy && !out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'(busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = 2'd0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  out_data,       32'h0);
        chk("rst_out_zero",  32'(out_zero),  32'h0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready_before_edge", 32'(in_ready), 32'h0);
        @(negedge clk);
        chk("rel_in_ready_after_edge", 32'(in_ready), 32'h1);

        // Directed vectors: mode, data, shamt, expected, latency in edges
        send(2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 8, 1'b1);
        send(2'd1, 32'h8000_0000, 5'd4,  32'hF800_0000, 1, 1'b1);
        send(2'd2, 32'h8000_0000, 5'd5,  32'h0400_0000, 2, 1'b1);
        send(2'd3, 32'h0000_00FF, 5'd8,  32'hFF00_0000, 2, 1'b1);
        send(2'd2, 32'h0000_0001, 5'd1,  32'h0000_0000, 1, 1'b1);
        send(2'd1, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF, 8, 1'b1);
        send(2'd3, 32'h1234_5678, 5'd31, 32'h2468_ACF0, 8, 1'b1);
        send(2'd0, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FF80, 2, 1'b1);
        send(2'd3, 32'h0000_0001, 5'd1,  32'h8000_0000, 1, 1'b1);
        send(2'd1, 32'h7FFF_FFFF, 5'd30, 32'h0000_0001, 8, 1'b1);

        // Zero shift amount: one waiting cycle in DONE, then the result
        wait_idle();
        send(2'd1, 32'h1234_5678, 5'd0, 32'h1234_5678, 1, 1'b1);
        chk("sh0_busy_wait",  32'(busy),      32'h1);
        chk("sh0_valid_wait", 32'(out_valid), 32'h0);
        @(negedge clk);
        chk("sh0_busy_valid", 32'(busy), 32'h1);
        @(negedge clk);
        chk("sh0_busy_after",     32'(busy),     32'h0);
        chk("sh0_in_ready_after", 32'(in_ready), 32'h1);

        // Back-pressure: result held for 5 cycles, new requests ignored
        wait_idle();
        out_ready = 1'b0;
        send(2'd2, 32'hF000_0000, 5'd3, 32'h1E00_0000, 1, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_valid_seen", 32'(out_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_shamt = 5'(i + 1);
            in_mode  = 2'(i);
            chk("hold_out_data",  out_data,        32'h1E00_0000);
            chk("hold_out_zero",  32'(out_zero),   32'h0);
            chk("hold_out_valid", 32'(out_valid),  32'h1);
            chk("hold_in_ready",  32'(in_ready),   32'h0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_out_valid", 32'(out_valid), 32'h0);
        chk("release_in_ready",  32'(in_ready),  32'h1);
        chk("release_busy",      32'(busy),      32'h0);

        // Reset in the middle of a long operation
        wait_idle();
        send(2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 8, 1'b0);
        @(negedge clk);
        chk("midrun_busy", 32'(busy), 32'h1);
        #2;
        rst      = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_out_data",  out_data,       32'h0);
        chk("midrst_out_zero",  32'(out_zero),  32'h0);
        chk("midrst_busy",      32'(busy),      32'h0);
        chk("midrst_in_ready",  32'(in_ready),  32'h0);
        repeat (2) @(negedge clk);
        chk("midrst_hold_in_ready", 32'(in_ready), 32'h0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("postrst_in_ready", 32'(in_ready), 32'h1);
        chk("postrst_busy",     32'(busy),     32'h0);
        repeat (12) @(negedge clk);

        // A normal request after the aborted one
        send(2'd2, 32'hF000_0000, 5'd3, 32'h1E00_0000, 1, 1'b1);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
